// File: rtl/vram_scanline_fetcher.sv
// vram_scanline_fetcher
//   Video-side VRAM client. Walks a scanline of word addresses into the 32-bit VRAM
//   read port, buffers the returned words in a small prefetch FIFO and serialises each
//   word into four 8bpp pixel indices (byte 0 = leftmost), paced by pixel_en_i.
//   Read latency: issue decision -> vram_addr_o (1 edge) -> VRAM samples (1 edge) ->
//   data pushed into the FIFO (1 edge), so a line's first word is poppable on the
//   fourth cycle after line_start_i.
//   Optional build macro: VRAM_FETCH_PIXEL_DOUBLE_EN (2x horizontal pixel doubling).

module vram_scanline_fetcher #(
    parameter int ADDR_W     = 15,
    parameter int LINE_WORDS = 80,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_i,
    input  logic              frame_start_i,
    input  logic              line_start_i,
    input  logic              pixel_en_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic [ADDR_W-1:0] vram_addr_o,
    input  logic [31:0]       vram_data_i,
    output logic [7:0]        pixel_o,
    output logic              pixel_valid_o,
    output logic              underflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WL_W  = $clog2(LINE_WORDS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] line_base;
    logic [WL_W-1:0]   words_left;

    // rd_addr_q: an issued address is on vram_addr_o; rd_data_q: its data is on vram_data_i.
    logic              rd_addr_q;
    logic              rd_data_q;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic [31:0]       head_word;
    logic [1:0]        sub;

    logic              flush;
    logic              fifo_empty;
    logic              issue;
    logic              push;
    logic              emit;
    logic              byte_done;
    logic              pop;

    // Datapath decisions for this cycle: issue, push, pixel emit and pop.
    // NOTE: every always_comb output is assigned unconditionally so no latch can be inferred.
    always_comb begin
        line_base  = frame_start_i ? base_addr_i : row_addr;
        flush      = frame_start_i | line_start_i;
        fifo_empty = (count == '0);
        occupancy  = (CNT_W+1)'(count) + (CNT_W+1)'(rd_addr_q) + (CNT_W+1)'(rd_data_q);
        issue      = (state == ST_FETCH) && (words_left != '0) && !flush &&
                     (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        push       = rd_data_q;
        head_word  = fifo_mem[rd_ptr];
        emit       = pixel_en_i && !fifo_empty;
        pop        = emit && byte_done && (sub == 2'd3);
    end

`ifdef VRAM_FETCH_PIXEL_DOUBLE_EN
    logic phase;

    // Each byte is shown for two strobes; the second strobe advances to the next byte.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i || line_start_i) begin
            phase <= 1'b0;
        end else if (emit) begin
            phase <= ~phase;
        end
    end

    assign byte_done = phase;
`else
    assign byte_done = 1'b1;
`endif

    // Line/frame sequencing, address generation and the IDLE/FETCH/DRAIN state machine.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i) begin
            state       <= ST_IDLE;
            row_addr    <= '0;
            fetch_addr  <= '0;
            words_left  <= '0;
            vram_addr_o <= '0;
        end else if (line_start_i) begin
            state      <= ST_FETCH;
            fetch_addr <= line_base;
            row_addr   <= line_base + ADDR_W'(LINE_WORDS);
            words_left <= WL_W'(LINE_WORDS);
        end else if (frame_start_i) begin
            state    <= ST_IDLE;
            row_addr <= base_addr_i;
        end else begin
            if (issue) begin
                vram_addr_o <= fetch_addr;
                fetch_addr  <= fetch_addr + ADDR_W'(1);
                words_left  <= words_left - WL_W'(1);
            end
            case (state)
                ST_FETCH: begin
                    if ((words_left == '0) || (issue && (words_left == WL_W'(1)))) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !rd_addr_q && !rd_data_q) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Follow each read through the VRAM pipeline; a flush discards reads still in flight.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i || flush) begin
            rd_addr_q <= 1'b0;
            rd_data_q <= 1'b0;
        end else begin
            rd_addr_q <= issue;
            rd_data_q <= rd_addr_q;
        end
    end

    // FIFO pointers and occupancy; the issue rule guarantees a push never meets a full FIFO.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage.
    // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= vram_data_i;
        end
    end

    // Pixel serialiser: one byte per strobe, sticky underflow when the line runs dry.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i) begin
            pixel_o       <= 8'h00;
            pixel_valid_o <= 1'b0;
            underflow_o   <= 1'b0;
            sub           <= 2'd0;
        end else begin
            pixel_valid_o <= 1'b0;
            if (pixel_en_i) begin
                if (!fifo_empty) begin
                    pixel_o       <= head_word[{sub, 3'b000} +: 8];
                    pixel_valid_o <= 1'b1;
                end else begin
                    pixel_o <= 8'h00;
                    if (state != ST_IDLE) begin
                        underflow_o <= 1'b1;
                    end
                end
            end
            if (flush) begin
                sub <= 2'd0;
            end else if (emit && byte_done) begin
                sub <= sub + 2'd1;
            end
            if (frame_start_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_scanline_fetcher.sv
// tb_vram_scanline_fetcher
//   Bench for vram_scanline_fetcher: a registered VRAM model with address-unique word
//   contents, a pixel scoreboard fed per line, a table of line vectors and hand-written
//   reset/underflow sequences. Honours VRAM_FETCH_PIXEL_DOUBLE_EN when defined.

`timescale 1ns/1ps

module tb_vram_scanline_fetcher;

    localparam int ADDR_W     = 15;
    localparam int LINE_WORDS = 80;
`ifdef VRAM_FETCH_PIXEL_DOUBLE_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif
    localparam int PIX_LINE = LINE_WORDS * 4 * REP;

    typedef struct {
        int              id;
        bit              frame;
        logic [ADDR_W-1:0] base;
        int              lead;
        int              strobes;
        int              gap;
        logic [ADDR_W-1:0] exp_start;
        bit              chk_last;
        logic [ADDR_W-1:0] exp_last;
    } line_vec_t;

    logic              wb_clk_i = 1'b0;
    logic              wb_reset_i;
    logic              frame_start_i;
    logic              line_start_i;
    logic              pixel_en_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] vram_addr_o;
    logic [31:0]       vram_data_i;
    logic [7:0]        pixel_o;
    logic              pixel_valid_o;
    logic              underflow_o;

    logic [31:0]       vram [32768];
    logic [7:0]        exp_q [$];
    line_vec_t         vecs [7];

    int checks = 0;
    int errors = 0;

    vram_scanline_fetcher #(
        .ADDR_W    (ADDR_W),
        .LINE_WORDS(LINE_WORDS),
        .FIFO_DEPTH(4)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_reset_i   (wb_reset_i),
        .frame_start_i(frame_start_i),
        .line_start_i (line_start_i),
        .pixel_en_i   (pixel_en_i),
        .base_addr_i  (base_addr_i),
        .vram_addr_o  (vram_addr_o),
        .vram_data_i  (vram_data_i),
        .pixel_o      (pixel_o),
        .pixel_valid_o(pixel_valid_o),
        .underflow_o  (underflow_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // VRAM read port: address sampled at an edge, data valid for the following cycle.
    always @(posedge wb_clk_i) vram_data_i <= vram[vram_addr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        logic [14:0] x;
        x = 15'(a);
        return {x[7:0] ^ 8'h3C, 1'b1, x[14:8], x[7:0], 1'b0, x[14:8]};
    endfunction

    // Queue the pixels a line starting at word 'start' must produce for 'n' strobes.
    task automatic push_line(input logic [ADDR_W-1:0] start, input int n);
        logic [ADDR_W-1:0] wa;
        logic [31:0]       w;
        int                b;
        for (int k = 0; k < n; k++) begin
            wa = start + ADDR_W'(k / (4 * REP));
            w  = vram[wa];
            b  = (k / REP) % 4;
            exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    // Scoreboard: every valid pixel must match the oldest queued expectation.
    always @(negedge wb_clk_i) begin
        if (pixel_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pixel_unexpected", {24'h0, pixel_o}, 32'hFFFF_FFFF);
            end else begin
                check("pixel", {24'h0, pixel_o}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_line(input line_vec_t v);
        frame_start_i = v.frame;
        base_addr_i   = v.base;
        line_start_i  = 1'b1;
        push_line(v.exp_start, v.strobes);
        @(negedge wb_clk_i);
        frame_start_i = 1'b0;
        line_start_i  = 1'b0;
        repeat (v.lead) @(negedge wb_clk_i);
        for (int s = 0; s < v.strobes; s++) begin
            pixel_en_i = 1'b1;
            @(negedge wb_clk_i);
            pixel_en_i = 1'b0;
            repeat (v.gap) @(negedge wb_clk_i);
        end
        for (int t = 0; t < 32 && exp_q.size() != 0; t++) @(negedge wb_clk_i);
        check($sformatf("line%0d_drain", v.id), 32'(exp_q.size()), 32'd0);
        check($sformatf("line%0d_underflow", v.id), {31'h0, underflow_o}, 32'd0);
        if (v.chk_last) begin
            check($sformatf("line%0d_last_addr", v.id), {17'h0, vram_addr_o}, {17'h0, v.exp_last});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 32768; a++) vram[a] = pat(a);
        vram[0] = 32'h4433_2211;
        vram[1] = 32'h8877_6655;

        //            id frame base     lead strobes   gap exp_start chk last
        vecs[0] = '{0, 1'b1, 15'h0000, 3, 8,        0, 15'h0000, 1'b0, 15'h0000};
        vecs[1] = '{1, 1'b1, 15'h0000, 3, PIX_LINE, 0, 15'h0000, 1'b1, 15'h004F};
        vecs[2] = '{2, 1'b0, 15'h0000, 3, PIX_LINE, 0, 15'h0050, 1'b1, 15'h009F};
        vecs[3] = '{3, 1'b1, 15'h7FF0, 3, PIX_LINE, 0, 15'h7FF0, 1'b1, 15'h003F};
        vecs[4] = '{4, 1'b0, 15'h0000, 3, PIX_LINE, 0, 15'h0040, 1'b1, 15'h008F};
        vecs[5] = '{5, 1'b1, 15'h1234, 5, 12,       1, 15'h1234, 1'b0, 15'h0000};
        vecs[6] = '{6, 1'b0, 15'h0000, 3, PIX_LINE, 2, 15'h1284, 1'b1, 15'h12D3};

        wb_reset_i    = 1'b0;
        frame_start_i = 1'b0;
        line_start_i  = 1'b0;
        pixel_en_i    = 1'b0;
        base_addr_i   = '0;

        // Reset held two cycles with pixel_en_i toggling: everything stays at zero.
        for (int i = 0; i < 2; i++) begin
            pixel_en_i = (i == 0);
            @(negedge wb_clk_i);
            check("rst_pixel", {24'h0, pixel_o}, 32'h0);
            check("rst_valid", {31'h0, pixel_valid_o}, 32'h0);
            check("rst_underflow", {31'h0, underflow_o}, 32'h0);
            check("rst_addr", {17'h0, vram_addr_o}, 32'h0);
        end
        wb_reset_i = 1'b1;
        pixel_en_i = 1'b1;
        @(negedge wb_clk_i);
        pixel_en_i = 1'b0;
        check("idle_valid", {31'h0, pixel_valid_o}, 32'h0);
        check("idle_underflow", {31'h0, underflow_o}, 32'h0);
        check("idle_addr", {17'h0, vram_addr_o}, 32'h0);

        // Table-driven lines: nibble check, full lines, address wrap, slower pixel rates.
        for (int v = 0; v < 7; v++) run_line(vecs[v]);

        // Strobe one cycle after line_start: underflow, zero pixel, not valid; sticky until frame.
        frame_start_i = 1'b1;
        base_addr_i   = 15'h0200;
        line_start_i  = 1'b1;
        @(negedge wb_clk_i);
        frame_start_i = 1'b0;
        line_start_i  = 1'b0;
        pixel_en_i    = 1'b1;
        @(negedge wb_clk_i);
        pixel_en_i = 1'b0;
        check("uf_set", {31'h0, underflow_o}, 32'h1);
        check("uf_pixel", {24'h0, pixel_o}, 32'h0);
        check("uf_valid", {31'h0, pixel_valid_o}, 32'h0);
        repeat (10) @(negedge wb_clk_i);
        check("uf_sticky", {31'h0, underflow_o}, 32'h1);
        line_start_i = 1'b1;
        @(negedge wb_clk_i);
        line_start_i = 1'b0;
        @(negedge wb_clk_i);
        check("uf_after_line", {31'h0, underflow_o}, 32'h1);
        frame_start_i = 1'b1;
        @(negedge wb_clk_i);
        frame_start_i = 1'b0;
        check("uf_cleared", {31'h0, underflow_o}, 32'h0);
        pixel_en_i = 1'b1;
        @(negedge wb_clk_i);
        pixel_en_i = 1'b0;
        check("frame_idle_valid", {31'h0, pixel_valid_o}, 32'h0);
        check("frame_idle_uf", {31'h0, underflow_o}, 32'h0);

        // Fill the FIFO, then reset mid-line: next cycle empty and idle, then a clean line from 0.
        frame_start_i = 1'b1;
        base_addr_i   = 15'h0100;
        line_start_i  = 1'b1;
        @(negedge wb_clk_i);
        frame_start_i = 1'b0;
        line_start_i  = 1'b0;
        repeat (10) @(negedge wb_clk_i);
        check("prefetch_stall_addr", {17'h0, vram_addr_o}, 32'h0103);
        wb_reset_i = 1'b0;
        pixel_en_i = 1'b1;
        @(negedge wb_clk_i);
        check("midrst_addr", {17'h0, vram_addr_o}, 32'h0);
        check("midrst_valid", {31'h0, pixel_valid_o}, 32'h0);
        wb_reset_i = 1'b1;
        @(negedge wb_clk_i);
        pixel_en_i = 1'b0;
        check("post_rst_valid", {31'h0, pixel_valid_o}, 32'h0);
        check("post_rst_uf", {31'h0, underflow_o}, 32'h0);
        run_line('{7, 1'b0, 15'h0000, 3, 8, 0, 15'h0000, 1'b0, 15'h0000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
